// File: rtl/proc_pkg.sv
// Shared processor-pipeline types: default datapath width and the skid-stage state encoding.
// The state encoding doubles as the occupancy count (EMPTY=0, ONE=1, FULL=2).
package proc_pkg;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry skid stage: full-throughput valid/ready register with a registered
// in_ready and a synchronous flush for branch/redirect.
module pipe_skid_stage
  import proc_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_t  state, state_nxt;
  logic [N-1:0] main_q, skid_q;
  logic         accept, pop;
  logic         load_main, load_skid, main_from_skid;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: if (accept) begin
        state_nxt = ST_ONE;
        load_main = 1'b1;
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      // in_ready is low in FULL, so only a pop can move us
      ST_FULL: if (pop) begin
        state_nxt      = ST_ONE;
        load_main      = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!reset) occupancy != 2'd3);
  a_skid_not_empty: assert property (@(posedge clk) disable iff (!reset)
                                     load_skid |-> (state != ST_EMPTY));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus a randomized run, all checked
// against a queue-based model of the stage contents.
module tb_pipe_skid_stage;
  localparam int N = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;

  pipe_skid_stage #(.N(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: words held by the stage, oldest first; m_rdy is what in_ready should read.
  logic [N-1:0] q[$];
  logic         m_rdy = 1'b0;

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0;
  endtask

  // One clock edge with the currently driven inputs; leaves time 1 unit past the edge.
  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && m_rdy;
    pp  = (q.size() > 0) && out_ready;
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    m_rdy = (q.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 24'hABCDEF; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== 24'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 000000", out_data); end
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_edge1: got %b want 1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_no_capture: occ %0d valid %b want 0/0", occupancy, out_valid); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = N'(i);
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== N'(i)) begin
        n_err++; $display("FAIL stream_word%0d: got %b/%h want 1/%h", i, out_valid, out_data, N'(i)); end
      n_cmp++; if (occupancy > 2'd1 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_occ%0d: occ %0d ready %b want <=1/1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_drain: occ %0d valid %b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'h111111; tick();
    in_data = 24'h222222; tick();
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full: occ %0d ready %b want 2/0", occupancy, in_ready); end
    n_cmp++; if (out_data !== 24'h111111) begin n_err++; $display("FAIL bp_head: got %h want 111111", out_data); end
    in_data = 24'h444444; tick();   // offered while full: must be ignored
    n_cmp++; if (occupancy !== 2'd2 || out_data !== 24'h111111) begin
      n_err++; $display("FAIL bp_hold: occ %0d data %h want 2/111111", occupancy, out_data); end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_cmp++; if (out_data !== 24'h222222 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL bp_second: data %h occ %0d want 222222/1", out_data, occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: occ %0d valid %b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'hAAAAA1; tick();
    in_data = 24'hAAAAA2; tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL fl_prefill: occ %0d want 2", occupancy); end
    flush = 1'b1; in_data = 24'h333333; tick();
    flush = 1'b0;
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL fl_empty: occ %0d valid %b ready %b want 0/0/1", occupancy, out_valid, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || (out_valid === 1'b1 && out_data === 24'h333333)) begin
        n_err++; $display("FAIL fl_dropped%0d: valid %b data %h want 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_random();
    int errs_shown = 0;
    bit stalled = 0;
    logic [N-1:0] held = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      in_data   = N'($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      stalled   = (q.size() > 0) && !out_ready && !flush;
      held      = (q.size() > 0) ? q[0] : '0;
      tick();
      n_cmp++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== m_rdy ||
          (q.size() > 0 && out_data !== q[0]) || (stalled && out_data !== held)) begin
        n_err++;
        if (errs_shown < 10) begin
          errs_shown++;
          $display("FAIL rand_c%0d: occ %0d valid %b ready %b data %h want %0d/%b/%b/%h",
                   c, occupancy, out_valid, in_ready, out_data, q.size(), q.size() > 0, m_rdy,
                   (q.size() > 0) ? q[0] : '0);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'h5A5A01; tick();
    in_data = 24'h5A5A02; tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL ar_prefill: occ %0d want 2", occupancy); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 24'h0) begin
      n_err++; $display("FAIL ar_clear: occ %0d valid %b ready %b data %h want 0/0/0/000000",
                        occupancy, out_valid, in_ready, out_data); end
    @(posedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL ar_restart: ready %b occ %0d want 1/0", in_ready, occupancy); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 24'hC0DE00 + N'(i);
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'hC0DE00 + N'(i)) begin
        n_err++; $display("FAIL ar_stream%0d: got %b/%h want 1/%h", i, out_valid, out_data, 24'hC0DE00 + N'(i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
